// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, load-type encodings
// and writeback FSM states.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational little-endian load alignment: picks the byte/half addressed
// by addr and sign- or zero-extends it; unknown load types pass the word.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] result
);

  logic [15:0] half_val;
  logic [7:0]  byte_val;
  load_type_e  lt;

  always_comb begin
    lt       = load_type_e'(load_type);
    // A misaligned halfword simply takes the half selected by bit 1.
    half_val = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    case (lt)
      LT_LH:   result = {{(DATA_W-16){half_val[15]}}, half_val};
      LT_LHU:  result = {{(DATA_W-16){1'b0}}, half_val};
      LT_LB:   result = {{(DATA_W-8){byte_val[7]}}, byte_val};
      LT_LBU:  result = {{(DATA_W-8){1'b0}}, byte_val};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write port, with a stall FSM
// that waits on variable-latency load data and a retired-instruction counter.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [2:0]        LoadTypeM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic              DataReadyM,
  input  logic              FlushW,
  output logic              StallMem,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic [CNT_W-1:0]  RetiredCount
);

  wb_state_e         state;
  logic              load_miss;
  logic              capture;
  logic              retire;
  logic [DATA_W-1:0] load_result;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .word      (ReadDataM),
    .addr      (ALUOutM[1:0]),
    .load_type (LoadTypeM),
    .result    (load_result)
  );

  // A flushed load never needs its data, so it does not start a wait.
  assign load_miss = ValidM & MemtoRegM & ~DataReadyM & ~FlushW;

  always_comb begin
    StallMem = 1'b0;
    capture  = 1'b0;
    if (state == ST_RUN) begin
      StallMem = load_miss;
      capture  = ~load_miss;
    end else begin
      StallMem = ~DataReadyM;
      capture  = DataReadyM;
    end
    if (RST) StallMem = 1'b0;
    retire = capture & ValidM & ~FlushW;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_RUN;
      RegWriteW    <= 1'b0;
      WriteRegW    <= '0;
      ResultW      <= '0;
      RetiredCount <= '0;
    end else begin
      case (state)
        ST_RUN:      state <= load_miss ? ST_WAIT_MEM : ST_RUN;
        ST_WAIT_MEM: state <= (FlushW | DataReadyM) ? ST_RUN : ST_WAIT_MEM;
        default:     state <= ST_RUN;
      endcase
      RegWriteW <= retire & RegWriteM & (WriteRegM != '0);
      // Bubbles leave the data/address registers untouched.
      if (retire) begin
        WriteRegW    <= WriteRegM;
        ResultW      <= MemtoRegM ? load_result : ALUOutM;
        RetiredCount <= RetiredCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU writes, $0 suppression,
// load alignment, memory wait, flush during wait and asynchronous reset.
module tb_writeback_stage;
  import mips_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ValidM = 1'b0;
  logic        RegWriteM = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic [2:0]  LoadTypeM = 3'd0;
  logic [4:0]  WriteRegM = 5'd0;
  logic [31:0] ALUOutM = 32'd0;
  logic [31:0] ReadDataM = 32'd0;
  logic        DataReadyM = 1'b0;
  logic        FlushW = 1'b0;
  logic        StallMem;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [31:0] RetiredCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  writeback_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .ValidM       (ValidM),
    .RegWriteM    (RegWriteM),
    .MemtoRegM    (MemtoRegM),
    .LoadTypeM    (LoadTypeM),
    .WriteRegM    (WriteRegM),
    .ALUOutM      (ALUOutM),
    .ReadDataM    (ReadDataM),
    .DataReadyM   (DataReadyM),
    .FlushW       (FlushW),
    .StallMem     (StallMem),
    .RegWriteW    (RegWriteW),
    .WriteRegW    (WriteRegW),
    .ResultW      (ResultW),
    .RetiredCount (RetiredCount)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; LoadTypeM = 0;
    WriteRegM = 0; ALUOutM = 0; DataReadyM = 0; FlushW = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] lt,
                          input logic [31:0] data, input logic rdy);
    ValidM = 1; RegWriteM = 1; MemtoRegM = 1; LoadTypeM = lt;
    WriteRegM = rd; ALUOutM = addr; ReadDataM = data; DataReadyM = rdy; FlushW = 0;
  endtask

  task automatic test_reset();
    set_idle();
    RST = 1;
    step(); step();
    checks += 5;
    if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", RegWriteW); end
    if (WriteRegW !== 5'd0) begin errors++; $display("FAIL reset_writereg got %0d want 0", WriteRegW); end
    if (ResultW !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", ResultW); end
    if (StallMem !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", StallMem); end
    if (RetiredCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", RetiredCount); end
    #2 RST = 0;
    step();
    $display("reset: RegWriteW=%0b ResultW=%h count=%0d", RegWriteW, ResultW, RetiredCount);
  endtask

  task automatic test_alu_write();
    ValidM = 1; RegWriteM = 1; MemtoRegM = 0; WriteRegM = 5'd8; ALUOutM = 32'h0000_1234;
    step();
    exp_cnt++;
    checks += 4;
    if (RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %0b want 1", RegWriteW); end
    if (WriteRegW !== 5'd8) begin errors++; $display("FAIL alu_writereg got %0d want 8", WriteRegW); end
    if (ResultW !== 32'h0000_1234) begin errors++; $display("FAIL alu_result got %h want 00001234", ResultW); end
    if (RetiredCount !== 32'd1) begin errors++; $display("FAIL alu_count got %0d want 1", RetiredCount); end
    $display("alu write: rd=%0d result=%h count=%0d", WriteRegW, ResultW, RetiredCount);
  endtask

  task automatic test_zero_reg();
    ValidM = 1; RegWriteM = 1; MemtoRegM = 0; WriteRegM = 5'd0; ALUOutM = 32'hFFFF_FFFF;
    step();
    exp_cnt++;
    checks += 3;
    if (RegWriteW !== 1'b0) begin errors++; $display("FAIL zero_regwrite got %0b want 0", RegWriteW); end
    if (ResultW !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_result got %h want ffffffff", ResultW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL zero_count got %0d want %0d", RetiredCount, exp_cnt); end
    $display("$0 write: RegWriteW=%0b count=%0d", RegWriteW, RetiredCount);
  endtask

  task automatic test_bubbles();
    // Invalid instruction with a stray DataReadyM: nothing retires, data holds.
    set_idle();
    RegWriteM = 1; WriteRegM = 5'd9; ALUOutM = 32'h1111_1111; DataReadyM = 1;
    #1;
    checks++;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL bubble_stall got %0b want 0", StallMem); end
    step();
    checks += 4;
    if (RegWriteW !== 1'b0) begin errors++; $display("FAIL bubble_regwrite got %0b want 0", RegWriteW); end
    if (WriteRegW !== 5'd0) begin errors++; $display("FAIL bubble_writereg got %0d want 0", WriteRegW); end
    if (ResultW !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bubble_result got %h want ffffffff", ResultW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL bubble_count got %0d want %0d", RetiredCount, exp_cnt); end
    $display("bubble: RegWriteW=%0b count=%0d", RegWriteW, RetiredCount);
    // Flushed valid ALU instruction.
    ValidM = 1; DataReadyM = 0; FlushW = 1;
    step();
    checks += 2;
    if (RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_run_regwrite got %0b want 0", RegWriteW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL flush_run_count got %0d want %0d", RetiredCount, exp_cnt); end
    $display("flush in RUN: RegWriteW=%0b count=%0d", RegWriteW, RetiredCount);
    set_idle();
  endtask

  task automatic test_load_align();
    logic [2:0]  lt_tab   [10] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd5};
    logic [1:0]  addr_tab [10] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] exp_tab  [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F02,
                                   32'h8081_7F02, 32'h0000_007F, 32'hFFFF_FF81, 32'h0000_7F02,
                                   32'h0000_8081, 32'h8081_7F02};
    for (int i = 0; i < 10; i++) begin
      set_load(5'(i + 10), {28'h0000_100, 2'b00, addr_tab[i]}, lt_tab[i], 32'h8081_7F02, 1'b1);
      #1;
      checks++;
      if (StallMem !== 1'b0) begin errors++; $display("FAIL align_stall[%0d] got %0b want 0", i, StallMem); end
      step();
      exp_cnt++;
      checks += 4;
      if (ResultW !== exp_tab[i]) begin errors++; $display("FAIL align_result[%0d] got %h want %h", i, ResultW, exp_tab[i]); end
      if (RegWriteW !== 1'b1) begin errors++; $display("FAIL align_regwrite[%0d] got %0b want 1", i, RegWriteW); end
      if (WriteRegW !== 5'(i + 10)) begin errors++; $display("FAIL align_writereg[%0d] got %0d want %0d", i, WriteRegW, i + 10); end
      if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL align_count[%0d] got %0d want %0d", i, RetiredCount, exp_cnt); end
      $display("load type=%0d addr=%0d result=%h", lt_tab[i], addr_tab[i], ResultW);
    end
    set_idle();
  endtask

  task automatic test_mem_wait();
    int stall_cycles = 0;
    set_load(5'd17, 32'h0000_2000, 3'd0, 32'hCAFE_F00D, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (StallMem === 1'b1) stall_cycles++;
      step();
      checks++;
      if (RegWriteW !== 1'b0) begin errors++; $display("FAIL wait_regwrite[%0d] got %0b want 0", c, RegWriteW); end
    end
    checks++;
    if (stall_cycles != 3) begin errors++; $display("FAIL wait_stall_cycles got %0d want 3", stall_cycles); end
    DataReadyM = 1;
    #1;
    checks++;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL wait_ready_stall got %0b want 0", StallMem); end
    step();
    exp_cnt++;
    set_idle();
    checks += 4;
    if (RegWriteW !== 1'b1) begin errors++; $display("FAIL wait_done_regwrite got %0b want 1", RegWriteW); end
    if (WriteRegW !== 5'd17) begin errors++; $display("FAIL wait_done_writereg got %0d want 17", WriteRegW); end
    if (ResultW !== 32'hCAFE_F00D) begin errors++; $display("FAIL wait_done_result got %h want cafef00d", ResultW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL wait_done_count got %0d want %0d", RetiredCount, exp_cnt); end
    #1;
    checks++;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL wait_after_stall got %0b want 0", StallMem); end
    $display("mem wait: stall cycles=%0d result=%h count=%0d", stall_cycles, ResultW, RetiredCount);
    step();
  endtask

  task automatic test_flush_wait();
    set_load(5'd20, 32'h0000_3000, 3'd0, 32'h1234_5678, 1'b0);
    step();
    #1;
    checks++;
    if (StallMem !== 1'b1) begin errors++; $display("FAIL fwait_stall1 got %0b want 1", StallMem); end
    step();
    FlushW = 1;
    #1;
    checks++;
    if (StallMem !== 1'b1) begin errors++; $display("FAIL fwait_stall2 got %0b want 1", StallMem); end
    step();
    set_idle();
    #1;
    checks += 3;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL fwait_after_stall got %0b want 0", StallMem); end
    if (RegWriteW !== 1'b0) begin errors++; $display("FAIL fwait_regwrite got %0b want 0", RegWriteW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL fwait_count got %0d want %0d", RetiredCount, exp_cnt); end
    $display("flush in WAIT_MEM: stall=%0b RegWriteW=%0b count=%0d", StallMem, RegWriteW, RetiredCount);
    step();
  endtask

  task automatic test_async_reset();
    set_load(5'd21, 32'h0000_4000, 3'd0, 32'h0BAD_BEEF, 1'b0);
    step();
    // In WAIT_MEM now; pulse reset well away from the clock edge.
    #2 RST = 1;
    #2;
    checks += 4;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL areset_stall got %0b want 0", StallMem); end
    if (ResultW !== 32'd0) begin errors++; $display("FAIL areset_result got %h want 0", ResultW); end
    if (WriteRegW !== 5'd0) begin errors++; $display("FAIL areset_writereg got %0d want 0", WriteRegW); end
    if (RetiredCount !== 32'd0) begin errors++; $display("FAIL areset_count got %0d want 0", RetiredCount); end
    set_idle();
    #1 RST = 0;
    exp_cnt = 0;
    step();
    checks++;
    if (StallMem !== 1'b0) begin errors++; $display("FAIL areset_run_stall got %0b want 0", StallMem); end
    ValidM = 1; RegWriteM = 1; WriteRegM = 5'd3; ALUOutM = 32'h0000_00AB;
    step();
    exp_cnt++;
    set_idle();
    checks += 4;
    if (RegWriteW !== 1'b1) begin errors++; $display("FAIL areset_alu_regwrite got %0b want 1", RegWriteW); end
    if (WriteRegW !== 5'd3) begin errors++; $display("FAIL areset_alu_writereg got %0d want 3", WriteRegW); end
    if (ResultW !== 32'h0000_00AB) begin errors++; $display("FAIL areset_alu_result got %h want 000000ab", ResultW); end
    if (RetiredCount !== exp_cnt) begin errors++; $display("FAIL areset_alu_count got %0d want %0d", RetiredCount, exp_cnt); end
    $display("async reset: post-reset ALU result=%h count=%0d", ResultW, RetiredCount);
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_zero_reg();
    test_bubbles();
    test_load_align();
    test_mem_wait();
    test_flush_wait();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
